// File: rtl/ray_gen_if.sv
// Ray and pixel-result port bundle between the ray generator, the intersect
// unit (ray_* / hit) and the framebuffer writer (pix_*).
interface ray_gen_if #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48
) ();
    logic                      ray_valid;
    logic                      ray_ready;
    logic [191:0]              ray_dir;
    logic                      hit;
    logic                      pix_valid;
    logic [$clog2(WIDTH)-1:0]  pix_x;
    logic [$clog2(HEIGHT)-1:0] pix_y;
    logic                      pix_hit;

    modport master (
        output ray_valid, ray_dir, pix_valid, pix_x, pix_y, pix_hit,
        input  ray_ready, hit
    );

    modport slave (
        input  ray_valid, ray_dir, pix_valid, pix_x, pix_y, pix_hit,
        output ray_ready, hit
    );
endinterface

// File: rtl/ray_gen.sv
// Raster-scan camera ray generator. Emits one exact IEEE-754 double direction
// vector per pixel on a valid/ready port, samples the intersect hit bit on each
// accepted ray and reports {x, y, hit} one cycle later.
module ray_gen #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int SHIFT  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    ray_gen_if.master  rg
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [63:0] DZ_NEG_ONE = 64'hBFF0000000000000;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           ray_valid_q, ray_valid_d;
    logic [191:0]   ray_dir_q, ray_dir_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pix_valid_q, pix_valid_d;
    logic [CW-1:0]  pix_x_q, pix_x_d;
    logic [RW-1:0]  pix_y_q, pix_y_d;
    logic           pix_hit_q, pix_hit_d;

    logic           hs;
    logic           last_pix;

    // Exact conversion of a small signed integer scaled by 2^-SHIFT to a double.
    // Magnitudes are far below 2^52, so the mantissa never needs rounding.
    function automatic logic [63:0] int_to_dbl(input logic signed [31:0] i);
        logic [31:0] m;
        int          p;
        logic [10:0] e;
        logic [51:0] frac;
        if (i == 32'sd0) begin
            return 64'h0;
        end
        m = i[31] ? 32'(-i) : 32'(i);
        p = 0;
        for (int k = 0; k < 32; k++) begin
            if (m[k]) p = k;
        end
        e    = 11'(1023 + p - SHIFT);
        frac = 52'(64'(m) << (52 - p));
        return {i[31], e, frac};
    endfunction

    // Direction for pixel (c, r): centred on the image, +y up, looking down -z.
    function automatic logic [191:0] dir_for(input logic [CW-1:0] c,
                                             input logic [RW-1:0] r);
        logic signed [31:0] ix;
        logic signed [31:0] iy;
        ix = signed'(32'(c)) - 32'(WIDTH / 2);
        iy = 32'(HEIGHT / 2) - signed'(32'(r));
        return {int_to_dbl(ix), int_to_dbl(iy), DZ_NEG_ONE};
    endfunction

    assign hs       = ray_valid_q & rg.ray_ready;
    assign last_pix = (col_q == CW'(WIDTH - 1)) && (row_q == RW'(HEIGHT - 1));

    // Next-state, scan advance and output register inputs.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        ray_valid_d = ray_valid_q;
        ray_dir_d   = ray_dir_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_hit_d   = pix_hit_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    col_d       = '0;
                    row_d       = '0;
                    ray_dir_d   = dir_for('0, '0);
                    ray_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = col_q;
                    pix_y_d     = row_q;
                    pix_hit_d   = rg.hit;
                    if (last_pix) begin
                        // Last pixel: ray_dir/col/row simply hold, valid drops.
                        ray_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else if (col_q == CW'(WIDTH - 1)) begin
                        col_d     = '0;
                        row_d     = row_q + 1'b1;
                        ray_dir_d = dir_for('0, row_q + 1'b1);
                    end else begin
                        col_d     = col_q + 1'b1;
                        ray_dir_d = dir_for(col_q + 1'b1, row_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            ray_valid_q <= 1'b0;
            ray_dir_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ray_valid_q <= ray_valid_d;
            ray_dir_q   <= ray_dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_hit_q   <= pix_hit_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rg.ray_valid = ray_valid_q;
    assign rg.ray_dir   = ray_dir_q;
    assign rg.pix_valid = pix_valid_q;
    assign rg.pix_x     = pix_x_q;
    assign rg.pix_y     = pix_y_q;
    assign rg.pix_hit   = pix_hit_q;
endmodule

// File: tb/tb_ray_gen.sv
// Scoreboard bench for ray_gen: handshakes push expected pixel results, a
// negedge monitor pops and compares on every pix_valid.
module tb_ray_gen;
    localparam int W    = 64;
    localparam int H    = 48;
    localparam int S    = 5;
    localparam int NPIX = W * H;
    localparam int CW   = $clog2(W);
    localparam int RW   = $clog2(H);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    ray_gen_if #(.WIDTH(W), .HEIGHT(H)) rif ();

    ray_gen #(.WIDTH(W), .HEIGHT(H), .SHIFT(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .rg    (rif.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [RW-1:0] y;
        logic          h;
    } pix_t;

    pix_t         sbq[$];
    pix_t         pe;
    pix_t         last_pop;
    int           checks = 0;
    int           errors = 0;
    int           ex_col = 0, ex_row = 0, ex_cnt = 0;
    int           pv_cnt = 0, done_cnt = 0;
    bit           bp_mode = 1'b0;
    logic         prev_stall = 1'b0;
    logic [191:0] prev_dir = '0;

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_dir(string name, logic [191:0] act, logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] model_dir(int c, int r);
        real sc;
        sc = real'(1 << S);
        return {$realtobits(real'(c - W / 2) / sc),
                $realtobits(real'(H / 2 - r) / sc),
                64'hBFF0000000000000};
    endfunction

    task automatic check_zero(string tag);
        chk_int({tag, "_busy"}, int'(busy), 0);
        chk_int({tag, "_done"}, int'(done), 0);
        chk_int({tag, "_ray_valid"}, int'(rif.ray_valid), 0);
        chk_dir({tag, "_ray_dir"}, rif.ray_dir, '0);
        chk_int({tag, "_pix_valid"}, int'(rif.pix_valid), 0);
        chk_int({tag, "_pix_x"}, int'(rif.pix_x), 0);
        chk_int({tag, "_pix_y"}, int'(rif.pix_y), 0);
        chk_int({tag, "_pix_hit"}, int'(rif.pix_hit), 0);
    endtask

    // Input drivers: ready/hit change 2 time units after each rising edge.
    initial begin
        rif.ray_ready = 1'b1;
        rif.hit       = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rif.ray_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            rif.hit       = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scoreboard pops on pix_valid, pushes on upcoming handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rif.pix_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pix_valid: got x=%0d y=%0d with empty queue",
                             rif.pix_x, rif.pix_y);
                end else begin
                    pe = sbq.pop_front();
                    chk_int("pix_x", int'(rif.pix_x), int'(pe.x));
                    chk_int("pix_y", int'(rif.pix_y), int'(pe.y));
                    chk_int("pix_hit", int'(rif.pix_hit), int'(pe.h));
                    last_pop = pe;
                    pv_cnt++;
                end
            end
            if (done) begin
                chk_int("done_with_pix_valid", int'(rif.pix_valid), 1);
                chk_int("done_last_x", int'(last_pop.x), W - 1);
                chk_int("done_last_y", int'(last_pop.y), H - 1);
                chk_int("done_busy_low", int'(busy), 0);
                chk_int("frame_pix_count", pv_cnt, NPIX);
                done_cnt++;
            end
            if (prev_stall && rif.ray_valid)
                chk_dir("stall_stable", rif.ray_dir, prev_dir);
            if (rif.ray_valid) begin
                chk_int("busy_with_valid", int'(busy), 1);
                if (rif.ray_ready) begin
                    chk_dir("ray_dir_model", rif.ray_dir, model_dir(ex_col, ex_row));
                    if (ex_col == 0 && ex_row == 0)
                        chk_dir("first_ray", rif.ray_dir,
                                {64'hBFF0000000000000, 64'h3FE8000000000000, 64'hBFF0000000000000});
                    if (ex_col == 32 && ex_row == 24)
                        chk_dir("center_ray", rif.ray_dir,
                                {64'h0, 64'h0, 64'hBFF0000000000000});
                    if (ex_col == 63 && ex_row == 47)
                        chk_dir("last_ray", rif.ray_dir,
                                {64'h3FEF000000000000, 64'hBFE7000000000000, 64'hBFF0000000000000});
                    if (ex_col == 0 && ex_row == 1)
                        chk_dir("row_wrap_ray", rif.ray_dir,
                                {64'hBFF0000000000000, 64'h3FE7000000000000, 64'hBFF0000000000000});
                    sbq.push_back('{x: CW'(ex_col), y: RW'(ex_row), h: rif.hit});
                    ex_cnt++;
                    if (ex_col == W - 1) begin
                        ex_col = 0;
                        ex_row++;
                    end else begin
                        ex_col++;
                    end
                end
            end
            prev_stall = rif.ray_valid && !rif.ray_ready;
            prev_dir   = rif.ray_dir;
        end
    end

    task automatic begin_frame();
        ex_col = 0;
        ex_row = 0;
        ex_cnt = 0;
        pv_cnt = 0;
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(string name, int limit);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no done after %0d cycles, required one", name, limit);
    endtask

    task automatic wait_pixels(string name, int n, int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (ex_cnt >= n) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got %0d pixels, required %0d", name, ex_cnt, n);
    endtask

    initial begin
        int d0;
        // Reset and idle
        #1 rst_n = 1'b0;
        #2 check_zero("in_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 check_zero("idle");
        end

        // Frame 1: ready held high
        bp_mode = 1'b0;
        begin_frame();
        wait_done("frame1", NPIX + 50);
        chk_int("frame1_done_count", done_cnt, 1);

        // Frame 2: backpressure plus a stray start mid-frame
        bp_mode = 1'b1;
        begin_frame();
        wait_pixels("frame2_mid", 1000, 4 * NPIX);
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("frame2", 6 * NPIX);
        chk_int("frame2_done_count", done_cnt, 2);
        bp_mode = 1'b0;
        repeat (3) @(posedge clk);

        // Frame 3: reset mid-frame at pixel 500
        begin_frame();
        wait_pixels("frame3_mid", 500, NPIX);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        sbq.delete();
        prev_stall = 1'b0;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check_zero("post_reset");
        end
        chk_int("no_done_after_reset", done_cnt, d0);

        // Frame 4: fresh start after reset begins at pixel (0,0)
        begin_frame();
        wait_done("frame4", NPIX + 50);
        chk_int("frame4_done_count", done_cnt, d0 + 1);
        chk_int("queue_drained", sbq.size(), 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
